// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: divider FSM encoding and default latency.
package pipe_ctrl_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/flush outputs shared between the datapath and pipe_ctrl.
interface pipe_ctrl_if;

  logic i_wait;
  logic d_wait;
  logic lu_hazard;
  logic br_flush;
  logic div_start;
  logic exc_valid;

  logic stallF;
  logic stallD;
  logic stallE;
  logic stallM;
  logic stallW;
  logic flushD;
  logic flushE;
  logic flushM;
  logic flushW;
  logic div_busy;
  logic div_done;

  modport master (
    output i_wait, d_wait, lu_hazard, br_flush, div_start, exc_valid,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  div_busy, div_done
  );

  modport slave (
    input  i_wait, d_wait, lu_hazard, br_flush, div_start, exc_valid,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output div_busy, div_done
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller with optional multi-cycle divider sequencing.
// The divider FSM and counter are only built when PIPE_CTRL_DIV_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.slave  bus
);

  logic mem_wait;
  logic div_busy_int;
  logic div_done_int;

  assign mem_wait = bus.i_wait | bus.d_wait;

`ifdef PIPE_CTRL_DIV_EN
  div_state_e       state;
  div_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_go;

  // A divide is only accepted when the pipe is free to advance into it.
  assign div_go = bus.div_start & ~mem_wait & ~bus.exc_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (div_go) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        // Counter keeps running through memory waits; only an exception aborts.
        if (bus.exc_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign div_busy_int = (state == BUSY) | ((state == IDLE) & div_go);
  assign div_done_int = (state == DONE);
`else
  logic unused_div;

  assign unused_div   = clk ^ bus.div_start ^ (CNT_W > 0) ^ (DIV_CYCLES > 0);
  assign div_busy_int = 1'b0;
  assign div_done_int = 1'b0;
`endif

  // Priority: exc_valid > mem_wait > div_busy > lu_hazard > br_flush.
  always_comb begin
    bus.stallF   = 1'b0;
    bus.stallD   = 1'b0;
    bus.stallE   = 1'b0;
    bus.stallM   = 1'b0;
    bus.stallW   = 1'b0;
    bus.flushD   = 1'b0;
    bus.flushE   = 1'b0;
    bus.flushM   = 1'b0;
    bus.flushW   = 1'b0;
    bus.div_busy = resetn & div_busy_int;
    bus.div_done = resetn & div_done_int;
    if (!resetn) begin
      bus.div_busy = 1'b0;
    end else if (bus.exc_valid) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
      bus.flushM = 1'b1;
      bus.flushW = 1'b1;
    end else if (mem_wait) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.stallE = 1'b1;
      bus.stallM = 1'b1;
      bus.stallW = 1'b1;
    end else if (div_busy_int) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.stallE = 1'b1;
      bus.flushM = 1'b1;
    end else if (bus.lu_hazard) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.flushE = 1'b1;
    end else if (bus.br_flush) begin
      bus.flushD = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: timestamp-based divider model plus priority rules.
module tb_pipe_ctrl;

  localparam int DC = 32;
`ifdef PIPE_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Vector order: stallF,D,E,M,W | flushD,E,M,W | div_busy | div_done
  localparam logic [10:0] ALL   = 11'h7FF;
  localparam logic [10:0] M_DIV = 11'b00100_0000_11;
  localparam logic [10:0] M_STD = 11'b11111_0000_11;

  logic clk = 1'b0;
  logic resetn;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  bit m_active = 1'b0;
  int m_start  = 0;

  logic [10:0] dv;
  assign dv = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW,
               bus.flushD, bus.flushE, bus.flushM, bus.flushW,
               bus.div_busy, bus.div_done};

  function automatic bit m_busy();
    return m_active && (cyc > m_start) && (cyc <= m_start + DC);
  endfunction

  function automatic bit m_done();
    return m_active && (cyc == m_start + DC + 1);
  endfunction

  function automatic bit m_go();
    return bus.div_start && !(bus.i_wait || bus.d_wait) && !bus.exc_valid;
  endfunction

  function automatic logic [10:0] exp_out();
    logic [10:0] v;
    bit bz;
    v = '0;
    if (resetn !== 1'b1) return v;
    bz = DIV_EN && (m_busy() || (!m_busy() && !m_done() && m_go()));
    if (bus.exc_valid)                 v[5:2]  = 4'b1111;
    else if (bus.i_wait || bus.d_wait) v[10:6] = 5'b11111;
    else if (bz) begin
      v[10:8] = 3'b111;
      v[3]    = 1'b1;
    end else if (bus.lu_hazard) begin
      v[10:9] = 2'b11;
      v[4]    = 1'b1;
    end else if (bus.br_flush)         v[5]    = 1'b1;
    v[1] = bz;
    v[0] = DIV_EN && m_done();
    return v;
  endfunction

  // Reference divider timeline, advanced on each rising edge.
  always @(posedge clk) begin
    if (resetn !== 1'b1) m_active <= 1'b0;
    else if (m_busy() || m_done()) begin
      if (bus.exc_valid || m_done()) m_active <= 1'b0;
    end else if (DIV_EN && m_go()) begin
      m_active <= 1'b1;
      m_start  <= cyc;
    end
    cyc <= cyc + 1;
  end

  logic [10:0] e_cmp;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cmp = exp_out();
      n_tests++;
      if (dv !== e_cmp) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d got=%b expected=%b", cyc, dv, e_cmp);
      end
      n_tests++;
      if ((dv[9:6] & dv[5:2]) !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_flush_overlap cyc=%0d got=%b expected no overlap", cyc, dv);
      end
    end
  end

  task automatic drive(input bit rn, input bit iw, input bit dw, input bit lu,
                       input bit br, input bit ds, input bit ex);
    resetn        = rn;
    bus.i_wait    = iw;
    bus.d_wait    = dw;
    bus.lu_hazard = lu;
    bus.br_flush  = br;
    bus.div_start = ds;
    bus.exc_valid = ex;
  endtask

  task automatic cycle_in(input bit rn, input bit iw, input bit dw, input bit lu,
                          input bit br, input bit ds, input bit ex);
    @(posedge clk);
    #1;
    drive(rn, iw, dw, lu, br, ds, ex);
    #2;
  endtask

  task automatic lit(input string nm, input int k, input logic [10:0] mask,
                     input logic [10:0] exp);
    n_tests++;
    if ((dv & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%b expected=%b mask=%b", nm, k, dv & mask, exp & mask, mask);
    end
  endtask

  initial begin
    logic [10:0] ev;
    drive(0, 0, 0, 0, 0, 1, 1);
    chk_en = 1'b1;
    #3;
    lit("reset_hold_a", 0, ALL, 11'b0);
    cycle_in(0, 0, 0, 0, 0, 1, 1);
    lit("reset_hold_b", 1, ALL, 11'b0);
    cycle_in(1, 0, 0, 0, 0, 0, 0);
    lit("post_reset_idle", 0, ALL, 11'b0);
    cycle_in(1, 0, 0, 0, 0, 0, 0);

`ifdef PIPE_CTRL_DIV_EN
    // Plain divide: busy 0..32, done at 33.
    for (int k = 0; k <= 35; k++) begin
      cycle_in(1, 0, 0, 0, 0, k <= 33, 0);
      ev = '0;
      if (k <= 32) ev = 11'b00100_0000_10;
      if (k == 33) ev = 11'b00000_0000_01;
      lit("divide", k, M_DIV, ev);
    end
    // Divide with a data-side wait in the middle of BUSY.
    for (int k = 0; k <= 35; k++) begin
      cycle_in(1, 0, (k >= 5) && (k <= 9), 0, 0, k <= 33, 0);
      ev = '0;
      if (k <= 32) ev = 11'b11100_0000_10;
      if (k >= 5 && k <= 9) ev = 11'b11111_0000_10;
      if (k == 33) ev = 11'b00000_0000_01;
      lit("divide_memwait", k, M_STD, ev);
    end
    // Exception aborts the divide at cycle 10.
    for (int k = 0; k <= 40; k++) begin
      cycle_in(1, 0, 0, 0, 0, k <= 10, k == 10);
      ev = '0;
      if (k < 10)  ev = 11'b11100_0010_10;
      if (k == 10) ev = 11'b00000_1111_10;
      lit("exc_abort", k, ALL, ev);
    end
`else
    for (int k = 0; k < 40; k++) begin
      cycle_in(1, 0, 0, 0, 0, 1, 0);
      lit("nodiv_start_ignored", k, ALL, 11'b0);
    end
`endif

    cycle_in(1, 0, 0, 1, 1, 0, 0);
    lit("prio_lu_over_br", 0, ALL, 11'b11000_0100_00);
    cycle_in(1, 0, 0, 0, 1, 0, 0);
    lit("br_alone", 0, ALL, 11'b00000_1000_00);
    cycle_in(1, 1, 0, 1, 1, 0, 0);
    lit("prio_memwait", 0, ALL, 11'b11111_0000_00);
    cycle_in(1, 0, 1, 1, 1, 0, 1);
    lit("prio_exc", 0, ALL, 11'b00000_1111_00);

    for (int k = 0; k < 3000; k++) begin
      cycle_in($urandom_range(0, 199) != 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 99) == 0);
    end

    cycle_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
